// File: rtl/clk_rst_pkg.sv
// Shared state encoding and default timing for the clock/reset sequencer.
package clk_rst_pkg;

  typedef enum logic [3:0] {
    StDcmRst  = 4'd0,
    StDcmWait = 4'd1,
    StPllRst  = 4'd2,
    StPllWait = 4'd3,
    StRelDdr  = 4'd4,
    StRelWb   = 4'd5,
    StRelDom  = 4'd6,
    StRun     = 4'd7,
    StFail    = 4'd8
  } state_e;

  localparam int unsigned DefDcmRstCycles = 4;
  localparam int unsigned DefPllRstCycles = 4;
  localparam int unsigned DefLockTimeout  = 65535;
  localparam int unsigned DefStageDelay   = 16;
  localparam int unsigned DefMaxRetries   = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; clears on synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clk_rst_seq.sv
// Board clock/reset sequencer: brings up DCM then PLL, then releases DDR2, Wishbone
// and core domain resets in stages, with lock supervision and bounded retries.
module clk_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int unsigned DCM_RST_CYCLES = DefDcmRstCycles,
  parameter int unsigned PLL_RST_CYCLES = DefPllRstCycles,
  parameter int unsigned LOCK_TIMEOUT   = DefLockTimeout,
  parameter int unsigned STAGE_DELAY    = DefStageDelay,
  parameter int unsigned MAX_RETRIES    = DefMaxRetries
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       dcm_locked_i,
  input  logic       pll_locked_i,
  input  logic       soft_rst_i,
  output logic       dcm_rst_o,
  output logic       pll_rst_o,
  output logic       ddr2_rst_o,
  output logic       wb_rst_o,
  output logic       dom_rst_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [1:0] retry_cnt_o,
  output logic       lock_lost_o,
  output logic [3:0] state_o
);

  localparam int unsigned MaxCycles =
      max_u(max_u(DCM_RST_CYCLES, PLL_RST_CYCLES), max_u(LOCK_TIMEOUT, STAGE_DELAY));
  localparam int unsigned CntW = $clog2(MaxCycles + 1);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t       CntMax      = {CntW{1'b1}};
  localparam cnt_t       DcmRstLast  = cnt_t'(DCM_RST_CYCLES - 1);
  localparam cnt_t       PllRstLast  = cnt_t'(PLL_RST_CYCLES - 1);
  localparam cnt_t       TimeoutLast = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t       StageLast   = cnt_t'(STAGE_DELAY - 1);
  localparam logic [1:0] RetryLimit  = 2'(MAX_RETRIES);

  logic dcm_lock_s;
  logic pll_lock_s;

  sync_2ff u_sync_dcm (
    .clk (sys_clk_i),
    .rst (sys_rst_i),
    .d   (dcm_locked_i),
    .q   (dcm_lock_s)
  );

  sync_2ff u_sync_pll (
    .clk (sys_clk_i),
    .rst (sys_rst_i),
    .d   (pll_locked_i),
    .q   (pll_lock_s)
  );

  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [1:0] retry_q, retry_d;
  logic       lost_q, lost_d;
  logic       dcm_rst_q, dcm_rst_d;
  logic       pll_rst_q, pll_rst_d;
  logic       ddr2_rst_q, ddr2_rst_d;
  logic       wb_rst_q, wb_rst_d;
  logic       dom_rst_q, dom_rst_d;
  logic       ready_q, ready_d;
  logic       fail_q, fail_d;

  logic lock_loss;
  logic timeout;
  logic restart;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    timeout = 1'b0;
    restart = 1'b0;

    // DCM lock is supervised once the PLL stage starts; PLL lock once domains release.
    lock_loss = ((state_q >= StPllRst) && (state_q <= StRun) && !dcm_lock_s) ||
                ((state_q >= StRelDdr) && (state_q <= StRun) && !pll_lock_s);

    if (soft_rst_i) begin
      state_d = StDcmRst;
      retry_d = 2'd0;
      lost_d  = 1'b0;
      restart = 1'b1;
    end else if (lock_loss) begin
      if (state_q == StRun) begin
        state_d = StDcmRst;
        retry_d = 2'd0;
        lost_d  = 1'b1;
      end else begin
        timeout = 1'b1;
      end
    end else begin
      unique case (state_q)
        StDcmRst:  if (cnt_q >= DcmRstLast) state_d = StDcmWait;
        StDcmWait: begin
          if (cnt_q >= TimeoutLast) timeout = 1'b1;
          else if (dcm_lock_s)      state_d = StPllRst;
        end
        StPllRst:  if (cnt_q >= PllRstLast) state_d = StPllWait;
        StPllWait: begin
          if (cnt_q >= TimeoutLast) timeout = 1'b1;
          else if (pll_lock_s)      state_d = StRelDdr;
        end
        StRelDdr:  if (cnt_q >= StageLast) state_d = StRelWb;
        StRelWb:   if (cnt_q >= StageLast) state_d = StRelDom;
        StRelDom:  if (cnt_q >= StageLast) state_d = StRun;
        StRun:     state_d = StRun;
        StFail:    state_d = StFail;
        default:   state_d = StDcmRst;
      endcase
    end

    if (timeout) begin
      if (retry_q == RetryLimit) begin
        state_d = StFail;
      end else begin
        state_d = StDcmRst;
        retry_d = retry_q + 2'd1;
      end
    end

    if (state_d == StRun) retry_d = 2'd0;

    if (restart || (state_d != state_q)) cnt_d = '0;
    else if (cnt_q == CntMax)            cnt_d = cnt_q;
    else                                 cnt_d = cnt_q + cnt_t'(1);

    // Outputs are registered from the next state so they line up with state_o.
    dcm_rst_d  = (state_d == StDcmRst) || (state_d == StFail);
    pll_rst_d  = (state_d <  StPllWait) || (state_d == StFail);
    ddr2_rst_d = (state_d <  StRelDdr) || (state_d == StFail);
    wb_rst_d   = (state_d <  StRelWb) || (state_d == StFail);
    dom_rst_d  = (state_d <  StRelDom) || (state_d == StFail);
    ready_d    = (state_d == StRun);
    fail_d     = (state_d == StFail);
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q    <= StDcmRst;
      cnt_q      <= '0;
      retry_q    <= 2'd0;
      lost_q     <= 1'b0;
      dcm_rst_q  <= 1'b1;
      pll_rst_q  <= 1'b1;
      ddr2_rst_q <= 1'b1;
      wb_rst_q   <= 1'b1;
      dom_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      lost_q     <= lost_d;
      dcm_rst_q  <= dcm_rst_d;
      pll_rst_q  <= pll_rst_d;
      ddr2_rst_q <= ddr2_rst_d;
      wb_rst_q   <= wb_rst_d;
      dom_rst_q  <= dom_rst_d;
      ready_q    <= ready_d;
      fail_q     <= fail_d;
    end
  end

  assign dcm_rst_o   = dcm_rst_q;
  assign pll_rst_o   = pll_rst_q;
  assign ddr2_rst_o  = ddr2_rst_q;
  assign wb_rst_o    = wb_rst_q;
  assign dom_rst_o   = dom_rst_q;
  assign ready_o     = ready_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = retry_q;
  assign lock_lost_o = lost_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq: bring-up, retries/fail, lock loss, soft and sys reset.
module tb_clk_rst_seq;

  localparam int unsigned DcmRst  = 4;
  localparam int unsigned PllRst  = 4;
  localparam int unsigned Timeout = 100;
  localparam int unsigned Stage   = 16;
  localparam int unsigned Retries = 3;

  localparam logic [3:0] SDcmRst  = 4'd0;
  localparam logic [3:0] SDcmWait = 4'd1;
  localparam logic [3:0] SRelDdr  = 4'd4;
  localparam logic [3:0] SRelWb   = 4'd5;
  localparam logic [3:0] SRelDom  = 4'd6;
  localparam logic [3:0] SRun     = 4'd7;
  localparam logic [3:0] SFail    = 4'd8;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       dcm_locked = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_rst = 1'b0;
  logic       dcm_rst, pll_rst, ddr2_rst, wb_rst, dom_rst, ready, fail, lock_lost;
  logic [1:0] retry_cnt;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  clk_rst_seq #(
    .DCM_RST_CYCLES (DcmRst),
    .PLL_RST_CYCLES (PllRst),
    .LOCK_TIMEOUT   (Timeout),
    .STAGE_DELAY    (Stage),
    .MAX_RETRIES    (Retries)
  ) dut (
    .sys_clk_i    (sys_clk),
    .sys_rst_i    (sys_rst),
    .dcm_locked_i (dcm_locked),
    .pll_locked_i (pll_locked),
    .soft_rst_i   (soft_rst),
    .dcm_rst_o    (dcm_rst),
    .pll_rst_o    (pll_rst),
    .ddr2_rst_o   (ddr2_rst),
    .wb_rst_o     (wb_rst),
    .dom_rst_o    (dom_rst),
    .ready_o      (ready),
    .fail_o       (fail),
    .retry_cnt_o  (retry_cnt),
    .lock_lost_o  (lock_lost),
    .state_o      (state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [3:0] st, input int budget,
                            output int cycles);
    cycles = 0;
    while (state != st && cycles < budget) begin
      step(1);
      cycles++;
    end
    if (state != st) check({tag, "_timeout"}, 32'(state), 32'(st));
  endtask

  task automatic count_dcm(input logic lvl, input int budget, output int cycles);
    cycles = 0;
    while (dcm_rst == lvl && cycles < budget) begin
      step(1);
      cycles++;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, 32'(state), 32'(SDcmRst));
    check({tag, "_dcm_rst"}, 32'(dcm_rst), 32'd1);
    check({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    check({tag, "_ddr2_rst"}, 32'(ddr2_rst), 32'd1);
    check({tag, "_wb_rst"}, 32'(wb_rst), 32'd1);
    check({tag, "_dom_rst"}, 32'(dom_rst), 32'd1);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_fail"}, 32'(fail), 32'd0);
    check({tag, "_retry"}, 32'(retry_cnt), 32'd0);
    check({tag, "_lost"}, 32'(lock_lost), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Nominal bring-up.
    dcm_locked = 1'b1;
    pll_locked = 1'b1;
    step(3);
    check_reset("por");
    sys_rst = 1'b0;
    step(3);
    check("nom_dcm_rst_held", 32'(dcm_rst), 32'd1);
    step(1);
    check("nom_dcm_rst_rel", 32'(dcm_rst), 32'd0);
    check("nom_dcm_wait", 32'(state), 32'(SDcmWait));
    wait_state("nom_ddr", SRelDdr, 50, cyc);
    check("nom_ddr_latency", 32'(cyc), 32'd6);
    check("nom_ddr_rst", 32'(ddr2_rst), 32'd0);
    check("nom_wb_held", 32'(wb_rst), 32'd1);
    wait_state("nom_wb", SRelWb, 50, cyc);
    check("nom_wb_gap", 32'(cyc), 32'd16);
    check("nom_wb_rst", 32'(wb_rst), 32'd0);
    check("nom_dom_held", 32'(dom_rst), 32'd1);
    wait_state("nom_dom", SRelDom, 50, cyc);
    check("nom_dom_gap", 32'(cyc), 32'd16);
    check("nom_dom_rst", 32'(dom_rst), 32'd0);
    wait_state("nom_run", SRun, 50, cyc);
    check("nom_run_gap", 32'(cyc), 32'd16);
    check("nom_ready", 32'(ready), 32'd1);
    check("nom_retry", 32'(retry_cnt), 32'd0);
    check("nom_pll_rst", 32'(pll_rst), 32'd0);

    // PLL lock drops in RUN: synchronizer latency then loss handling.
    pll_locked = 1'b0;
    step(2);
    check("pll_loss_ready_still", 32'(ready), 32'd1);
    step(1);
    check("pll_loss_state", 32'(state), 32'(SDcmRst));
    check("pll_loss_ready", 32'(ready), 32'd0);
    check("pll_loss_ddr2", 32'(ddr2_rst), 32'd1);
    check("pll_loss_wb", 32'(wb_rst), 32'd1);
    check("pll_loss_dom", 32'(dom_rst), 32'd1);
    check("pll_loss_lost", 32'(lock_lost), 32'd1);
    check("pll_loss_retry", 32'(retry_cnt), 32'd0);
    pll_locked = 1'b1;
    wait_state("pll_loss_rerun", SRun, 300, cyc);
    check("pll_loss_rerun_ready", 32'(ready), 32'd1);
    check("pll_loss_sticky", 32'(lock_lost), 32'd1);

    // DCM lock drops in RUN, then soft reset races a PLL drop in REL_WB.
    dcm_locked = 1'b0;
    step(3);
    check("dcm_loss_state", 32'(state), 32'(SDcmRst));
    check("dcm_loss_retry", 32'(retry_cnt), 32'd0);
    dcm_locked = 1'b1;
    wait_state("race_wb", SRelWb, 300, cyc);
    step(2);
    pll_locked = 1'b0;
    step(2);
    soft_rst = 1'b1;
    step(1);
    soft_rst = 1'b0;
    check("race_state", 32'(state), 32'(SDcmRst));
    check("race_retry", 32'(retry_cnt), 32'd0);
    check("race_lost", 32'(lock_lost), 32'd0);
    check("race_wb_rst", 32'(wb_rst), 32'd1);
    pll_locked = 1'b1;

    // sys_rst pulsed in REL_DOM.
    wait_state("mid_dom", SRelDom, 300, cyc);
    step(3);
    sys_rst = 1'b1;
    step(1);
    check_reset("mid_rst");
    sys_rst = 1'b0;

    // DCM never locks: four attempts, three retries, then FAIL.
    sys_rst = 1'b1;
    dcm_locked = 1'b0;
    pll_locked = 1'b0;
    step(2);
    sys_rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      count_dcm(1'b1, 20, cyc);
      check($sformatf("nolock_pulse%0d", a), 32'(cyc), 32'd4);
      check($sformatf("nolock_retry%0d", a), 32'(retry_cnt), 32'(a));
      check($sformatf("nolock_pll_rst%0d", a), 32'(pll_rst), 32'd1);
      count_dcm(1'b0, 200, cyc);
      check($sformatf("nolock_wait%0d", a), 32'(cyc), 32'd100);
    end
    check("fail_flag", 32'(fail), 32'd1);
    check("fail_state", 32'(state), 32'(SFail));
    check("fail_retry", 32'(retry_cnt), 32'd3);
    check("fail_resets", 32'({dcm_rst, pll_rst, ddr2_rst, wb_rst, dom_rst}), 32'h1f);
    check("fail_ready", 32'(ready), 32'd0);
    step(20);
    check("fail_sticky", 32'(state), 32'(SFail));
    soft_rst = 1'b1;
    step(1);
    soft_rst = 1'b0;
    check("fail_soft_state", 32'(state), 32'(SDcmRst));
    check("fail_soft_flag", 32'(fail), 32'd0);
    check("fail_soft_retry", 32'(retry_cnt), 32'd0);
    step(4);
    check("fail_soft_restart", 32'(state), 32'(SDcmWait));

    // DCM locks on the second attempt.
    sys_rst = 1'b1;
    dcm_locked = 1'b0;
    pll_locked = 1'b1;
    step(2);
    sys_rst = 1'b0;
    count_dcm(1'b1, 20, cyc);
    count_dcm(1'b0, 200, cyc);
    check("second_retry_rst", 32'(retry_cnt), 32'd1);
    dcm_locked = 1'b1;
    wait_state("second_ddr", SRelDdr, 50, cyc);
    check("second_retry_seq", 32'(retry_cnt), 32'd1);
    wait_state("second_run", SRun, 100, cyc);
    check("second_retry_run", 32'(retry_cnt), 32'd0);
    check("second_ready", 32'(ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
